// File: rtl/stream_pkg.sv
// Shared types and sizing helpers for the parameterised stream FIFO.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package stream_pkg;

    // Largest supported FIFO depth.
    localparam int unsigned MAX_DEPTH = 256;

    // Default payload word.
    typedef logic [7:0] byte_t;

    // Bits needed to hold the values 0..n inclusive (occupancy counters).
    function automatic int unsigned clog2p1(input int unsigned n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/wrap_ptr.sv
// Modulo-DEPTH pointer counter; wraps DEPTH-1 -> 0 by explicit compare.
// Latency: pointer advances on the clock edge after inc is sampled high.
// Backpressure: none; the caller qualifies inc.
// Ports: clk, rst (async active-high), inc (advance request), ptr (current value).
module wrap_ptr #(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     inc,
    output logic [$clog2(DEPTH)-1:0] ptr
);

    localparam int unsigned PW = $clog2(DEPTH);

    logic [PW-1:0] ptr_q;
    logic [PW-1:0] ptr_d;

    // DEPTH need not be a power of two, so wrap on compare rather than overflow.
    always_comb begin
        ptr_d = ptr_q;
        if (inc) begin
            if (ptr_q == PW'(DEPTH - 1)) begin
                ptr_d = '0;
            end else begin
                ptr_d = ptr_q + PW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr = ptr_q;

endmodule

// File: rtl/param_stream_fifo.sv
// Valid/ready FIFO with occupancy count, almost-full watermark and sticky overflow.
// Latency: 1 cycle push-to-head; 0 cycles when FALLTHROUGH=1 and the FIFO is empty.
// Backpressure: in_ready = not full, registered; no combinational path from out_ready.
// Ports: clk, rst (async active-high); in_valid/in_ready/in_data producer side;
//        out_valid/out_ready/out_data consumer side; count, almost_full, overflow status.
module param_stream_fifo
    import stream_pkg::*;
#(
    parameter type         T           = byte_t,
    parameter int unsigned DEPTH       = 4,
    parameter int unsigned AFULL_LVL   = DEPTH - 1,
    parameter bit          FALLTHROUGH = 1'b0
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  T                            in_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output T                            out_data,
    output logic [clog2p1(DEPTH)-1:0]   count,
    output logic                        almost_full,
    output logic                        overflow
);

    localparam int unsigned CW = clog2p1(DEPTH);
    localparam int unsigned PW = $clog2(DEPTH);

    if (DEPTH < 2 || DEPTH > MAX_DEPTH || AFULL_LVL > DEPTH) begin : g_bad_params
        $error("param_stream_fifo: DEPTH must be 2..%0d and AFULL_LVL <= DEPTH", MAX_DEPTH);
    end

    T mem [DEPTH];

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;
    logic          overflow_q;
    logic          overflow_d;

    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;

    logic empty;
    logic full;
    logic bypass;
    logic bypass_xfer;
    logic push;
    logic pop;
    logic wr_en;
    logic rd_inc;

    assign empty = (count_q == '0);
    assign full  = (count_q == CW'(DEPTH));

    // Fallthrough presents the producer word directly when nothing is stored.
    assign bypass      = FALLTHROUGH && empty && in_valid;
    assign bypass_xfer = bypass && out_ready;

    assign in_ready  = !full;
    assign out_valid = !empty || bypass;
    assign out_data  = bypass ? in_data : mem[rd_ptr];

    assign push = in_valid && in_ready;
    assign pop  = out_valid && out_ready;

    // A word that passes straight through never touches storage or pointers.
    assign wr_en  = push && !bypass_xfer;
    assign rd_inc = pop && !bypass_xfer;

    always_comb begin
        count_d = count_q;
        case ({wr_en, rd_inc})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    assign overflow_d = overflow_q || (in_valid && !in_ready);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage is deliberately left unreset; pointers and count define validity.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= in_data;
        end
    end

    wrap_ptr #(.DEPTH(DEPTH)) u_wr_ptr (
        .clk (clk),
        .rst (rst),
        .inc (wr_en),
        .ptr (wr_ptr)
    );

    wrap_ptr #(.DEPTH(DEPTH)) u_rd_ptr (
        .clk (clk),
        .rst (rst),
        .inc (rd_inc),
        .ptr (rd_ptr)
    );

    assign count       = count_q;
    assign almost_full = (count_q >= CW'(AFULL_LVL));
    assign overflow    = overflow_q;

endmodule

// File: tb/tb_param_stream_fifo.sv
`timescale 1ns/1ps
module tb_param_stream_fifo;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // DEPTH=4 registered
    logic       a_iv, a_ir, a_ov, a_or, a_af, a_of;
    logic [7:0] a_id, a_od;
    logic [2:0] a_cnt;
    param_stream_fifo #(.DEPTH(4)) u_a (
        .clk(clk), .rst(rst), .in_valid(a_iv), .in_ready(a_ir), .in_data(a_id),
        .out_valid(a_ov), .out_ready(a_or), .out_data(a_od), .count(a_cnt),
        .almost_full(a_af), .overflow(a_of));

    // DEPTH=3 registered
    logic       b_iv, b_ir, b_ov, b_or, b_af, b_of;
    logic [7:0] b_id, b_od;
    logic [1:0] b_cnt;
    param_stream_fifo #(.DEPTH(3)) u_b (
        .clk(clk), .rst(rst), .in_valid(b_iv), .in_ready(b_ir), .in_data(b_id),
        .out_valid(b_ov), .out_ready(b_or), .out_data(b_od), .count(b_cnt),
        .almost_full(b_af), .overflow(b_of));

    // DEPTH=4 fallthrough
    logic       c_iv, c_ir, c_ov, c_or, c_af, c_of;
    logic [7:0] c_id, c_od;
    logic [2:0] c_cnt;
    param_stream_fifo #(.DEPTH(4), .FALLTHROUGH(1'b1)) u_c (
        .clk(clk), .rst(rst), .in_valid(c_iv), .in_ready(c_ir), .in_data(c_id),
        .out_valid(c_ov), .out_ready(c_or), .out_data(c_od), .count(c_cnt),
        .almost_full(c_af), .overflow(c_of));

    // 32-bit, DEPTH=5, AFULL_LVL=5
    logic        w_iv, w_ir, w_ov, w_or, w_af, w_of;
    logic [31:0] w_id, w_od;
    logic [2:0]  w_cnt;
    param_stream_fifo #(.T(logic [31:0]), .DEPTH(5), .AFULL_LVL(5)) u_w (
        .clk(clk), .rst(rst), .in_valid(w_iv), .in_ready(w_ir), .in_data(w_id),
        .out_valid(w_ov), .out_ready(w_or), .out_data(w_od), .count(w_cnt),
        .almost_full(w_af), .overflow(w_of));

    logic [31:0] sb_q[$];
    logic [31:0] exp_v;
    logic [7:0]  pat [4];

    initial begin
        a_iv = 0; a_id = 0; a_or = 0;
        b_iv = 0; b_id = 0; b_or = 0;
        c_iv = 0; c_id = 0; c_or = 0;
        w_iv = 0; w_id = 0; w_or = 0;
        pat[0] = 8'h11; pat[1] = 8'h22; pat[2] = 8'h33; pat[3] = 8'h44;

        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_count", 32'(a_cnt), 0);
        chk("rst_out_valid", 32'(a_ov), 0);
        chk("rst_in_ready", 32'(a_ir), 1);
        chk("rst_almost_full", 32'(a_af), 0);
        chk("rst_overflow", 32'(a_of), 0);

        // Fill DEPTH=4 with consumer stalled.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            a_iv = 1'b1; a_id = pat[i];
            @(posedge clk); #1;
            chk("fill_count", 32'(a_cnt), 32'(i + 1));
            chk("fill_afull", 32'(a_af), 32'((i + 1) >= 3));
            chk("fill_head", 32'(a_od), 32'h11);
        end
        chk("full_in_ready", 32'(a_ir), 0);

        // Write attempt while full sets sticky overflow.
        @(negedge clk);
        a_iv = 1'b1; a_id = 8'h55;
        @(posedge clk); #1;
        chk("ovf_set", 32'(a_of), 1);
        chk("ovf_count", 32'(a_cnt), 4);
        @(negedge clk);
        a_iv = 1'b0;
        @(posedge clk); #1;
        chk("ovf_sticky", 32'(a_of), 1);

        // Drain in order.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            a_or = 1'b1; #1;
            chk("drain_valid", 32'(a_ov), 1);
            chk("drain_data", 32'(a_od), 32'(pat[i]));
            @(posedge clk);
        end
        @(negedge clk);
        a_or = 1'b0; #1;
        chk("drain_count", 32'(a_cnt), 0);
        chk("drain_out_valid", 32'(a_ov), 0);

        // DEPTH=3 steady-state push/pop; pointers wrap twice.
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            b_iv = (k < 8); b_id = 8'(8'hB0 + k); b_or = (k > 0); #1;
            if (k > 0) chk("wrap_count", 32'(b_cnt), 1);
            if (b_ov && b_or) begin
                if (sb_q.size() == 0) chk("wrap_sb_empty", 32'(b_ov), 0);
                else begin
                    exp_v = sb_q.pop_front();
                    chk("wrap_data", 32'(b_od), exp_v);
                end
            end
            if (b_iv && b_ir) sb_q.push_back(32'(b_id));
            @(posedge clk);
        end
        @(negedge clk);
        b_iv = 0; b_or = 0; #1;
        chk("wrap_final_count", 32'(b_cnt), 0);
        chk("wrap_sb_left", 32'(sb_q.size()), 0);
        sb_q.delete();

        // Fallthrough on empty.
        @(negedge clk);
        c_iv = 1'b1; c_id = 8'hA5; c_or = 1'b1; #1;
        chk("ft_valid", 32'(c_ov), 1);
        chk("ft_data", 32'(c_od), 32'hA5);
        @(posedge clk); #1;
        chk("ft_count", 32'(c_cnt), 0);
        @(negedge clk);
        c_iv = 1'b0; c_or = 1'b0; #1;
        chk("ft_idle_valid", 32'(c_ov), 0);

        // Async reset mid-cycle with two words stored and overflow set.
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            a_iv = 1'b1; a_id = 8'(8'hC0 + i);
            @(posedge clk);
        end
        @(negedge clk);
        a_iv = 1'b0; #1;
        chk("prerst_count", 32'(a_cnt), 2);
        #1 rst = 1'b1;
        #1;
        chk("arst_count", 32'(a_cnt), 0);
        chk("arst_out_valid", 32'(a_ov), 0);
        chk("arst_overflow", 32'(a_of), 0);
        chk("arst_in_ready", 32'(a_ir), 1);
        #1 rst = 1'b0;
        @(negedge clk);
        a_iv = 1'b1; a_id = 8'h77;
        @(posedge clk); #1;
        chk("postrst_head", 32'(a_od), 32'h77);
        chk("postrst_count", 32'(a_cnt), 1);
        @(negedge clk);
        a_iv = 1'b0;

        // Random traffic on the 32-bit FIFO against a queue model.
        for (int n = 0; n < 10000; n++) begin
            @(negedge clk);
            chk("rnd_count", 32'(w_cnt), 32'(sb_q.size()));
            chk("rnd_afull", 32'(w_af), 32'(sb_q.size() == 5));
            w_iv = 1'($urandom_range(0, 1)) & w_ir;
            w_id = $urandom;
            w_or = 1'($urandom_range(0, 1));
            #1;
            if (w_ov && w_or) begin
                if (sb_q.size() == 0) chk("rnd_sb_empty", 32'(w_ov), 0);
                else begin
                    exp_v = sb_q.pop_front();
                    chk("rnd_data", w_od, exp_v);
                end
            end
            if (w_iv && w_ir) sb_q.push_back(w_id);
        end
        @(negedge clk);
        w_iv = 0; w_or = 0; #1;
        chk("rnd_overflow", 32'(w_of), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
